obstacle_field: RTL
===================

# obstacle_field

Downstream consumer of the 8-bit player-position register in the dodge game. It generates falling obstacles on an 8×8 field and checks them against the player position on the bottom row. It also counts dodged obstacles and latches game-over. Its outputs drive the LED matrix scan and the score display.

## Interface
- TICK_DIV, default 12_500_000: CLK cycles per fall step (4 Hz at 50 MHz). Must be ≥2.
- SEED, default 8'h01: LFSR reset value. If 0, 8'h01 is used.
- CLK  in  1  system clock; all logic on posedge.
- init  in  1  reset, synchronous, active-low.
- player  in  8  player position, active-low. The zero bit marks the player column; bit c is column c.
- field  out  64  obstacle map, active-high. field[8*r+c] is row r, column c; row 0 is the top and row 7 is the player row.
- score  out  8  obstacles dodged, binary, saturating.
- game_over  out  1  high while in OVER.
- tick  out  1  one-cycle pulse on each fall step.

## Operation
- States: RUN and OVER. Reset puts the block in RUN.
- Reset values: field = 0, score = 0, game_over = 0, tick = 0, tick counter = 0, lfsr = SEED (or 8'h01 if SEED is 0), state = RUN.
- Tick counter:
  - Counts 0..TICK_DIV-1 in RUN and wraps to 0.
  - tick = 1 in the cycle the counter equals TICK_DIV-1.
  - In OVER the counter holds and tick = 0.
- hit = |(field[63:56] & ~player), taken from current registers every cycle. Any zero bit of player counts, including multi-zero or all-zero values.
- Priority in RUN, each cycle:
  - If hit: go to OVER. No shift, no score change, even if tick is high in the same cycle.
  - Else if tick: perform the fall step below.
  - Else: hold.
- Fall step, all updates from pre-step values:
  - row r ← row r-1, for r = 1..7.
  - row 0 ← spawn row.
  - score ← score+1 (saturating at 255) if old row 7 ≠ 0.
  - lfsr advances.
- Spawn row:
  - If lfsr[3] = 1 and old row 0 = 0: one-hot, with the 1 at column lfsr[2:0].
  - Otherwise: 8'h00.
  - This guarantees at least one empty row between obstacles.
- LFSR (8-bit Fibonacci): lfsr ← {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}. It only advances on a fall step in RUN.
- OVER:
  - field, score and lfsr are frozen; game_over = 1.
  - The only exit is init = 0.
- Reset mid-operation: init = 0 on any clock edge restores all reset values, regardless of state or tick.

## Timing
- All outputs are registered.
- tick: high for exactly one cycle.
  - First pulse is in cycle TICK_DIV-1 after init rises (counting the first cycle with init = 1 as 0).
  - The fall step takes effect on the edge ending that cycle.
- Fall step: field and score update at the edge where tick = 1.
- game_over: asserts on the first edge after hit becomes true.
  - Obstacle arrival: one cycle after the row-7 update.
  - Player moving into an obstacle: one cycle after player changes.
- Row travel: an obstacle spawned at fall step n occupies row r after fall step n+r and leaves the field at step n+8. Score increments at step n+8.
- player is used directly in the hit compare and is not registered here. Upstream already registers it on CLK.

## Test plan
Use TICK_DIV = 4 and SEED = 8'h01 throughout.
- Reset/idle: hold init = 0 for 3 cycles, then release -> field = 0, score = 0, game_over = 0; tick pulses every 4 cycles, first pulse in cycle 3.
- Spawn sequence: player = 8'b01111111, run 4 fall steps.
  - Steps 1–3 (lfsr 01, 02, 04) -> row 0 = 0.
  - Step 4 (lfsr 08) -> row 0 = 8'h01; lfsr then = 8'h11.
- Dodge: player = 8'b01111111 -> column-0 obstacle reaches row 7 at step 11; score goes 0→1 at step 12; game_over stays 0.
- Collision by arrival: player = 8'b11111110 -> row 7 = 8'h01 after step 11; game_over = 1 one cycle later. field and score then stay frozen for ≥20 cycles with tick = 0.
- Collision by movement, same-cycle priority:
  - At step 11, hold player = 8'b01111111; 2 cycles later set player = 8'b11111110 -> game_over next cycle.
  - Repeat with the hit aligned to a tick cycle -> no shift occurs.
- Reset from OVER and saturation:
  - Pulse init = 0 in OVER -> all reset values restored; replayed spawn sequence is identical.
  - Force score to 255 via a long dodge run -> further dodges keep score at 255.

Source files
------------

// File: rtl/obstacle_field.sv
// obstacle_field: falling-obstacle generator and collision checker for the dodge game.
// Obstacles are spawned pseudo-randomly into the top row of an 8x8 field.
// Each fall step moves them down one row. An obstacle that falls off the bottom row
// without touching the player adds one to the score. A collision latches game-over.
//
// Ports:
//   CLK        system clock, all logic on posedge
//   init       synchronous active-low reset
//   player     [7:0]  player column, active-low (zero bit = occupied column)
//   field      [63:0] obstacle map, field[8*r+c] = row r / column c, row 7 = player row
//   score      [7:0]  dodged obstacles, saturating at 255
//   game_over  high while in OVER
//   tick       one-cycle pulse on each fall step
module obstacle_field #(
    parameter int unsigned TICK_DIV = 12_500_000,
    parameter logic [7:0]  SEED     = 8'h01
) (
    input  logic        CLK,
    input  logic        init,
    input  logic [7:0]  player,
    output logic [63:0] field,
    output logic [7:0]  score,
    output logic        game_over,
    output logic        tick
);

    localparam int unsigned CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TICK_DIV - 1);
    localparam logic [7:0] SEED_EFF = (SEED == 8'h00) ? 8'h01 : SEED;

    typedef enum logic {RUN, OVER} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic          tick_nx;
    logic [63:0]   field_nx;
    logic [7:0]    score_nx;
    logic [7:0]    lfsr, lfsr_nx;
    logic [7:0]    spawn;
    logic          hit;

    // Any obstacle in the player row under any player column is a collision.
    assign hit = |(field[63:56] & ~player);

    // Spawn only when the top row is empty, which keeps a gap row between obstacles.
    assign spawn = (lfsr[3] && (field[7:0] == 8'h00)) ? (8'd1 << lfsr[2:0]) : 8'h00;

    // State and output registers.
    always_ff @(posedge CLK) begin
        if (!init) begin
            state     <= RUN;
            cnt       <= '0;
            tick      <= 1'b0;
            field     <= '0;
            score     <= '0;
            lfsr      <= SEED_EFF;
            game_over <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            tick      <= tick_nx;
            field     <= field_nx;
            score     <= score_nx;
            lfsr      <= lfsr_nx;
            game_over <= (state_nx == OVER);
        end
    end

    // Next-state logic: collision takes priority over a fall step in the same cycle.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        tick_nx  = 1'b0;
        field_nx = field;
        score_nx = score;
        lfsr_nx  = lfsr;
        case (state)
            RUN: begin
                if (hit) begin
                    state_nx = OVER;
                end else begin
                    cnt_nx  = (cnt == CNT_LAST) ? '0 : cnt + CW'(1);
                    // tick is registered, so it is raised as the counter enters its last value.
                    tick_nx = (cnt_nx == CNT_LAST);
                    if (tick) begin
                        field_nx = {field[55:0], spawn};
                        if ((field[63:56] != 8'h00) && (score != 8'hFF))
                            score_nx = score + 8'd1;
                        lfsr_nx  = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
                    end
                end
            end
            OVER: begin
                state_nx = OVER;
            end
            default: state_nx = RUN;
        endcase
    end

endmodule
